// File: rtl/regfile_scoreboard_if.sv
// Purpose : register-file / scoreboard port bundle: writeback, reserve and two read ports.
// Latency : none of its own; plain wires between the driver and the register file.
// Backpres: none; every strobe is accepted on the edge at which it is presented.
//
// Ports (DUT view, slave modport):
//   i_wEnable/i_wAddr/i_wData  writeback strobe, index and data
//   i_Issue/i_IssueAddr        reserve strobe and destination index
//   i_rAddr_1/i_rAddr_2        combinational read indices
//   o_rData_1/o_rData_2        read data
//   o_rBusy_1/o_rBusy_2        read operand still pending
//   o_BusyCount/o_Full         number of reserved registers, all writable registers reserved
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            i_wEnable;
    logic [AW-1:0]   i_wAddr;
    logic [XLEN-1:0] i_wData;
    logic            i_Issue;
    logic [AW-1:0]   i_IssueAddr;
    logic [AW-1:0]   i_rAddr_1;
    logic [AW-1:0]   i_rAddr_2;
    logic [XLEN-1:0] o_rData_1;
    logic [XLEN-1:0] o_rData_2;
    logic            o_rBusy_1;
    logic            o_rBusy_2;
    logic [AW:0]     o_BusyCount;
    logic            o_Full;

    // Pipeline / decode side: drives strobes and indices, consumes read results.
    modport master (
        output i_wEnable, i_wAddr, i_wData,
        output i_Issue, i_IssueAddr,
        output i_rAddr_1, i_rAddr_2,
        input  o_rData_1, o_rData_2,
        input  o_rBusy_1, o_rBusy_2,
        input  o_BusyCount, o_Full
    );

    // Register file side.
    modport slave (
        input  i_wEnable, i_wAddr, i_wData,
        input  i_Issue, i_IssueAddr,
        input  i_rAddr_1, i_rAddr_2,
        output o_rData_1, o_rData_2,
        output o_rBusy_1, o_rBusy_2,
        output o_BusyCount, o_Full
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Purpose : NREGS x XLEN register file (x0 hard-wired to zero) with a per-register busy scoreboard.
// Latency : reads are combinational (optionally forwarding a same-cycle writeback); state updates on i_Clk rise.
// Backpres: none; issue to an already-busy register, or while full, simply leaves it busy.
//
// Ports:
//   i_Clk    single rising-edge clock
//   i_Reset  asynchronous active-low reset; clears data, busy bits and the busy counter
//   bus      regfile_scoreboard_if.slave: writeback, reserve, two read ports, busy count, full flag
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW    = $clog2(NREGS);
    localparam int CW    = AW + 1;
    localparam bit BYP   = (BYPASS != 0);
    localparam logic [CW-1:0] FULL_CNT = CW'(NREGS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  mem_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    busy_count_q;
    logic [CW-1:0]    busy_count_nxt;

    // ------------------------------------------------------------------
    // Qualified strobes: index 0 is never written nor reserved
    // ------------------------------------------------------------------
    logic wr_vld;
    logic iss_vld;
    logic same_idx;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_vld   = bus.i_wEnable && (bus.i_wAddr != '0);
    assign iss_vld  = bus.i_Issue && (bus.i_IssueAddr != '0);
    assign same_idx = (bus.i_wAddr == bus.i_IssueAddr);

    // A reservation only adds to the count when the target bit was clear.
    // A writeback only subtracts when it clears a set bit and the same
    // index is not being re-reserved on this edge (issue wins the tie).
    assign cnt_inc = iss_vld && !busy_q[bus.i_IssueAddr];
    assign cnt_dec = wr_vld && busy_q[bus.i_wAddr] && !(iss_vld && same_idx);

    // ------------------------------------------------------------------
    // Next busy vector: clear on writeback first, then set on issue so a
    // same-index collision ends busy.
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy_q;
        if (wr_vld) begin
            busy_nxt[bus.i_wAddr] = 1'b0;
        end
        if (iss_vld) begin
            busy_nxt[bus.i_IssueAddr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        busy_count_nxt = busy_count_q + CW'(cnt_inc) - CW'(cnt_dec);
    end

    // ------------------------------------------------------------------
    // Register file storage
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_vld) begin
            mem_q[bus.i_wAddr] <= bus.i_wData;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard state: busy bits and their running population count.
    // The counter is kept alongside the vector so o_BusyCount and o_Full
    // come straight from a flop instead of a wide popcount tree.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_nxt;
            busy_count_q <= busy_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // Forwarding is suppressed while reset is held so that reads return
    // zero regardless of what the writeback bus carries.
    logic fwd_1;
    logic fwd_2;

    assign fwd_1 = BYP && i_Reset && wr_vld && (bus.i_wAddr == bus.i_rAddr_1);
    assign fwd_2 = BYP && i_Reset && wr_vld && (bus.i_wAddr == bus.i_rAddr_2);

    always_comb begin
        bus.o_rData_1 = '0;
        bus.o_rBusy_1 = 1'b0;
        if (bus.i_rAddr_1 != '0) begin
            if (fwd_1) begin
                bus.o_rData_1 = bus.i_wData;
                bus.o_rBusy_1 = 1'b0;
            end else begin
                bus.o_rData_1 = mem_q[bus.i_rAddr_1];
                bus.o_rBusy_1 = busy_q[bus.i_rAddr_1];
            end
        end
    end

    always_comb begin
        bus.o_rData_2 = '0;
        bus.o_rBusy_2 = 1'b0;
        if (bus.i_rAddr_2 != '0) begin
            if (fwd_2) begin
                bus.o_rData_2 = bus.i_wData;
                bus.o_rBusy_2 = 1'b0;
            end else begin
                bus.o_rData_2 = mem_q[bus.i_rAddr_2];
                bus.o_rBusy_2 = busy_q[bus.i_rAddr_2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign bus.o_BusyCount = busy_count_q;
    assign bus.o_Full      = (busy_count_q == FULL_CNT);
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every register in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, a power of two from 2 to 64; AW = $clog2(NREGS).
REQ-003 SHALL have parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding, 0 disables it.
REQ-004 i_Clk  input  1  single clock, all state updates on rising edge.
REQ-005 i_Reset  input  1  asynchronous active-low reset.
REQ-006 i_wEnable  input  1  writeback strobe.
REQ-007 i_wAddr  input  AW  writeback register index.
REQ-008 i_wData  input  XLEN  writeback data.
REQ-009 i_Issue  input  1  reserve strobe; marks a destination register pending.
REQ-010 i_IssueAddr  input  AW  register index to reserve.
REQ-011 i_rAddr_1, i_rAddr_2  input  AW each  read port indices.
REQ-012 o_rData_1, o_rData_2  output  XLEN each  read data.
REQ-013 o_rBusy_1, o_rBusy_2  output  1 each  read operand still pending (hazard).
REQ-014 o_BusyCount  output  AW+1  number of registers currently marked busy.
REQ-015 o_Full  output  1  all NREGS-1 writable registers busy.

Function
REQ-016 Register 0 SHALL read as zero on both ports at all times; writes and issues to index 0 are ignored, busy[0] is constant 0.
REQ-017 On rising edge with i_wEnable=1 and i_wAddr!=0, mem[i_wAddr] SHALL take i_wData.
REQ-018 Read ports SHALL be combinational: o_rData_n = mem[i_rAddr_n], zero for index 0.
REQ-019 With BYPASS=1, when i_wEnable=1, i_wAddr==i_rAddr_n, i_wAddr!=0, o_rData_n SHALL equal i_wData in the same cycle; with BYPASS=0 it shows the old value until the next cycle.
REQ-020 Busy vector SHALL be one bit per register; i_Issue with i_IssueAddr!=0 sets busy[i_IssueAddr] at the edge.
REQ-021 i_wEnable with i_wAddr!=0 SHALL clear busy[i_wAddr] at the edge; writing a non-busy register is legal and leaves it clear.
REQ-022 Issue and writeback to the same nonzero index in one cycle: data written, busy SHALL end set (issue wins).
REQ-023 Issue to an already-busy register SHALL leave it busy and not change o_BusyCount.
REQ-024 o_rBusy_n = busy[i_rAddr_n]; with BYPASS=1 it SHALL be 0 when a same-cycle writeback to that nonzero index is present (operand is forwarded).
REQ-025 o_BusyCount SHALL be a registered counter: +1 per edge on which a clear bit becomes set, -1 per edge on which a set bit becomes clear, net 0 when both occur on different indices; it SHALL always equal the popcount of busy.
REQ-026 o_Full SHALL be 1 exactly when o_BusyCount == NREGS-1; an issue while full to a busy index is a no-op, no error state.
REQ-027 Undefined-index handling is not required: all AW-bit indices are valid because NREGS is a power of two.

Reset
REQ-028 On i_Reset=0, asynchronously and independent of i_Clk: all mem entries 0, all busy bits 0, o_BusyCount 0, o_Full 0.
REQ-029 While i_Reset=0, i_wEnable and i_Issue SHALL be ignored; reads return 0, o_rBusy_n 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending reservations; first edge after deassertion behaves as a normal cycle.

Verification
REQ-031 Reset, then write x5=0xDEADBEEF; next cycle read port 1 addr 5 -> 0xDEADBEEF, port 2 addr 0 -> 0.
REQ-032 BYPASS=1: same cycle wEnable addr 7 data 0x12345678 with rAddr_1=7 -> o_rData_1=0x12345678, o_rBusy_1=0; BYPASS=0 -> old value 0.
REQ-033 Issue x3, x4, x3 on three edges -> o_BusyCount 1,2,2; writeback x3 -> count 1, o_rBusy for 3 is 0.
REQ-034 Same-cycle issue and writeback to x9 with data 0xA5 -> mem[9]=0xA5, busy[9]=1, count unchanged from +1.
REQ-035 Issue x1..x31 (NREGS=32) -> o_BusyCount 31, o_Full 1; assert i_Reset low mid-clock -> immediately count 0, o_Full 0, all reads 0.
REQ-036 Write and issue targeting x0 -> read x0 = 0, o_rBusy 0, o_BusyCount unchanged.
